snoop_bus_ctrl: RTL and testbench
=================================

Name: snoop_bus_ctrl

Overview:
- Shared snooping-bus controller that sits directly downstream of the per-line MESI state machines.
- Collects BusRd / BusRdX / BusUpgr requests from NUM_CORES cache agents and grants one at a time, round-robin.
- Broadcasts the granted transaction to all other caches and gathers their shared (C) and flush responses.
- Sequences the memory read or writeback, then returns completion plus the shared flag to the requester; that flag drives the requester's C_in.

Parameters:
- NUM_CORES, 4, number of cache agents on the bus (2..8).
- ADDR_W, 32, line address width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_CORES  per-core request; held high until that core's done pulse.
- req_cmd  in  NUM_CORES*2  per-core command (bus_cmd_t).
- req_addr  in  NUM_CORES*ADDR_W  per-core line address.
- bus_gnt  out  NUM_CORES  one-hot; high from SNOOP through DONE for the granted core.
- snoop_valid  out  1  broadcast strobe, one cycle per transaction.
- snoop_cmd  out  2  broadcast command.
- snoop_addr  out  ADDR_W  broadcast address.
- snoop_src  out  $clog2(NUM_CORES)  index of the requester.
- snoop_shared  in  NUM_CORES  per-core "line present" response; sampled in the SNOOP cycle.
- snoop_flush  in  NUM_CORES  per-core "M copy flushed" response; sampled in the SNOOP cycle.
- mem_rd_req  out  1  memory read request; held until mem_ack.
- mem_wr_req  out  1  memory writeback request; held until mem_ack.
- mem_addr  out  ADDR_W  latched address.
- mem_ack  in  1  memory completion.
- done  out  NUM_CORES  one-cycle completion pulse to the requester.
- shared_out  out  1  valid with done; feeds the requester's C_in.
- err  out  1  sticky protocol error.

Behaviour:
- Command encoding: 01 BusRd, 10 BusRdX, 11 BusUpgr, 00 NONE.
  - A request with cmd 00 is ineligible and never granted.
- Reset:
  - State goes to IDLE.
  - All outputs are 0.
  - last_grant is set to NUM_CORES-1, so core 0 has first priority.
  - Reset mid-transaction aborts immediately: no done pulse, mem requests drop the same cycle.
- IDLE:
  - If any eligible req_valid, pick the first requester after last_grant, wrapping modulo NUM_CORES.
  - Latch src, cmd and addr, then go to SNOOP.
  - Requests arriving later wait in the queue. There is no preemption.
- SNOOP (exactly 1 cycle):
  - snoop_valid=1 and bus_gnt[src]=1.
  - Sample sh = snoop_shared & ~(1<<src) and fl = snoop_flush & ~(1<<src). The requester's own responses are masked.
  - Next state:
    - any fl → FLUSH;
    - else cmd==BusUpgr → DONE;
    - else → MEM.
  - If popcount(fl)>1, set err (sticky until rst) and continue as single flush.
  - If cmd==BusUpgr and fl≠0, set err.
- FLUSH:
  - mem_wr_req=1 with mem_addr=addr until mem_ack, then DONE.
  - The flushed data serves the requester, so the memory read is skipped.
- MEM:
  - mem_rd_req=1 until mem_ack, then DONE.
  - mem_ack is sampled only in MEM/FLUSH; mem_ack in other states is ignored.
  - An ack in the first MEM cycle is legal.
- DONE (1 cycle):
  - done[src]=1.
  - shared_out = (|sh) for BusRd, or 0 for BusRdX/BusUpgr.
  - last_grant=src, then IDLE.
- Latency (request seen in IDLE at cycle t):
  - snoop_valid at t+1.
  - BusUpgr with no flush: done at t+2.
  - BusRd / BusRdX: done at one cycle after the mem_ack cycle.
- Next grant: can occur in the IDLE cycle right after DONE (minimum 3-cycle transaction spacing).
- Simultaneous requests: resolved purely by round-robin.
- Requester behaviour: if a requester drops req_valid before done, the transaction still completes.
- Outputs: registered, except mem_rd_req/mem_wr_req/snoop_valid/done/shared_out, which are decoded from registered state only, with no combinational path from inputs.

Decomposition:
- Shared package (bus_pkg):
  - bus_cmd_t enum (NONE/BUSRD/BUSRDX/BUSUPGR);
  - bus_state_t enum (IDLE/SNOOP/FLUSH/MEM/DONE).
- One sub-module: rr_arbiter.
  - Parameter N; inputs req[N], last[$clog2(N)]; outputs gnt_idx and any.
  - Purely combinational rotate-priority; reused by other bus masters.

Test Plan:
- Single BusRd, core 2, addr 0x1000, no sharers, mem_ack after 3 cycles → snoop_valid at t+1 with src=2; mem_rd_req held 3 cycles; done[2] with shared_out=0.
- BusRd from core 0 with snoop_shared=4'b0110 → shared_out=1.
  - Repeat with snoop_shared=4'b0001 (own bit only) → shared_out=0.
- BusRd from core 1 with snoop_flush[3]=1 → mem_wr_req (not mem_rd_req) until mem_ack; done[1]; err=0.
- BusUpgr from core 3 → done[3] at t+2, no mem request, shared_out=0.
- All four cores request continuously → grant order 0,1,2,3,0 with exactly one bus_gnt bit high at any time.
- rst asserted during MEM → next cycle all outputs 0 and state IDLE.
  - After rst: snoop_flush=4'b1010 on a BusRd from core 0 → err=1 and it stays 1 until rst.

Source files
------------

// File: rtl/snoop_bus_ctrl_pkg.sv
// Purpose: shared bus command and controller state types for the snooping bus.
// Latency: n/a (types only).
// Backpressure: n/a.
// Contents: bus_cmd_t (request/broadcast command), bus_state_t (controller phase).
package bus_pkg;

    // Encoding is visible on req_cmd/snoop_cmd, so values are fixed.
    typedef enum logic [1:0] {
        NONE    = 2'b00,
        BUSRD   = 2'b01,
        BUSRDX  = 2'b10,
        BUSUPGR = 2'b11
    } bus_cmd_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNOOP = 3'd1,
        FLUSH = 3'd2,
        MEM   = 3'd3,
        DONE  = 3'd4
    } bus_state_t;

endpackage

// File: rtl/snoop_bus_ctrl_if.sv
// Purpose: bundle of cache-agent request, snoop broadcast/response and memory signals.
// Latency: n/a (wires only).
// Backpressure: requests are held by agents until their done pulse; memory holds off via mem_ack.
// Ports: master = bus controller side, slave = cache agents + memory side.
interface snoop_bus_ctrl_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32
);
    localparam int SRC_W = $clog2(NUM_CORES);

    logic [NUM_CORES-1:0]        req_valid;
    logic [NUM_CORES*2-1:0]      req_cmd;
    logic [NUM_CORES*ADDR_W-1:0] req_addr;
    logic [NUM_CORES-1:0]        bus_gnt;
    logic                        snoop_valid;
    logic [1:0]                  snoop_cmd;
    logic [ADDR_W-1:0]           snoop_addr;
    logic [SRC_W-1:0]            snoop_src;
    logic [NUM_CORES-1:0]        snoop_shared;
    logic [NUM_CORES-1:0]        snoop_flush;
    logic                        mem_rd_req;
    logic                        mem_wr_req;
    logic [ADDR_W-1:0]           mem_addr;
    logic                        mem_ack;
    logic [NUM_CORES-1:0]        done;
    logic                        shared_out;
    logic                        err;

    modport master (
        input  req_valid, req_cmd, req_addr, snoop_shared, snoop_flush, mem_ack,
        output bus_gnt, snoop_valid, snoop_cmd, snoop_addr, snoop_src,
               mem_rd_req, mem_wr_req, mem_addr, done, shared_out, err
    );

    modport slave (
        output req_valid, req_cmd, req_addr, snoop_shared, snoop_flush, mem_ack,
        input  bus_gnt, snoop_valid, snoop_cmd, snoop_addr, snoop_src,
               mem_rd_req, mem_wr_req, mem_addr, done, shared_out, err
    );
endinterface

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Purpose: rotate-priority arbiter; picks the first requester after 'last', wrapping.
// Latency: combinational.
// Backpressure: none; caller decides when to consume gnt_idx.
// Ports: req[N] in, last in, gnt_idx out (valid when any), any out.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] gnt_idx,
    output logic         any
);
    int idx;

    // Walk offsets from farthest to nearest so the nearest requester after
    // 'last' is the one left standing.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                gnt_idx = W'(idx);
                any     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/snoop_bus_ctrl.sv
// Purpose: snooping-bus controller; round-robin grant, snoop broadcast, memory read/writeback, completion.
// Latency: snoop 1 cycle after grant; done 1 cycle after mem_ack (BusUpgr without flush: 2 cycles after grant).
// Backpressure: one transaction at a time; other requesters wait with req_valid held; memory stalls via mem_ack.
// Ports: clk, rst (sync, active-high); bus = controller side of snoop_bus_ctrl_if.
module snoop_bus_ctrl
    import bus_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    snoop_bus_ctrl_if.master  bus
);
    localparam int SRC_W = $clog2(NUM_CORES);

    bus_state_t             state;
    bus_cmd_t               cmd;
    logic [SRC_W-1:0]       src;
    logic [SRC_W-1:0]       lastGrant;
    logic [ADDR_W-1:0]      addr;
    logic [NUM_CORES-1:0]   gnt;
    logic                   shAny;
    logic                   errSticky;

    logic [NUM_CORES-1:0]   eligible;
    logic [SRC_W-1:0]       arbIdx;
    logic                   arbAny;
    logic [NUM_CORES-1:0]   srcMask;
    logic [NUM_CORES-1:0]   shMasked;
    logic [NUM_CORES-1:0]   flMasked;
    logic                   flMulti;

    // A NONE command never competes for the bus.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            eligible[i] = bus.req_valid[i] && (bus.req_cmd[2*i +: 2] != NONE);
        end
    end

    rr_arbiter #(.N(NUM_CORES), .W(SRC_W)) uArb (
        .req     (eligible),
        .last    (lastGrant),
        .gnt_idx (arbIdx),
        .any     (arbAny)
    );

    // The requester's own snoop responses are meaningless and masked off.
    assign srcMask  = NUM_CORES'(1) << src;
    assign shMasked = bus.snoop_shared & ~srcMask;
    assign flMasked = bus.snoop_flush & ~srcMask;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign flMulti  = |(flMasked & (flMasked - NUM_CORES'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd       <= NONE;
            src       <= '0;
            lastGrant <= SRC_W'(NUM_CORES - 1);
            addr      <= '0;
            gnt       <= '0;
            shAny     <= 1'b0;
            errSticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arbAny) begin
                        src   <= arbIdx;
                        cmd   <= bus_cmd_t'(bus.req_cmd[2*arbIdx +: 2]);
                        addr  <= bus.req_addr[ADDR_W*arbIdx +: ADDR_W];
                        gnt   <= NUM_CORES'(1) << arbIdx;
                        state <= SNOOP;
                    end
                end
                SNOOP: begin
                    shAny <= |shMasked;
                    if (|flMasked) begin
                        // Multiple M owners or an upgrade against an M copy are
                        // protocol violations; carry on with a single writeback.
                        if (flMulti || cmd == BUSUPGR) begin
                            errSticky <= 1'b1;
                        end
                        state <= FLUSH;
                    end else if (cmd == BUSUPGR) begin
                        state <= DONE;
                    end else begin
                        state <= MEM;
                    end
                end
                FLUSH, MEM: begin
                    if (bus.mem_ack) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    lastGrant <= src;
                    gnt       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.bus_gnt     = gnt;
    assign bus.snoop_valid = (state == SNOOP);
    assign bus.snoop_cmd   = cmd;
    assign bus.snoop_addr  = addr;
    assign bus.snoop_src   = src;
    assign bus.mem_rd_req  = (state == MEM);
    // A flushed M copy already supplies the requester, so only the writeback runs.
    assign bus.mem_wr_req  = (state == FLUSH);
    assign bus.mem_addr    = addr;
    assign bus.done        = (state == DONE) ? gnt : '0;
    assign bus.shared_out  = (state == DONE) && (cmd == BUSRD) && shAny;
    assign bus.err         = errSticky;
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
module tb_snoop_bus_ctrl;
    import bus_pkg::*;

    localparam int NC = 4;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snoop_bus_ctrl_if #(.NUM_CORES(NC), .ADDR_W(AW)) busIf ();

    snoop_bus_ctrl #(.NUM_CORES(NC), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          src;
        int          lat;
        int          rd;
        int          wr;
        int          snoops;
        int          gntBad;
        logic        sh;
        logic        err;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [3:0]  doneVec;
    } obs_t;

    typedef struct {
        int   lat;
        int   rd;
        int   wr;
        logic sh;
        logic errNew;
    } exp_t;

    typedef struct {
        int          core;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [3:0]  sh;
        logic [3:0]  fl;
        int          ack;
        int          lat;
        int          rd;
        int          wr;
        logic        shOut;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutsZero(input string name);
        logic [127:0] v;
        v = {47'd0, busIf.bus_gnt, busIf.snoop_valid, busIf.snoop_cmd, busIf.snoop_addr,
             busIf.snoop_src, busIf.mem_rd_req, busIf.mem_wr_req, busIf.mem_addr,
             busIf.done, busIf.shared_out, busIf.err};
        total++;
        if (v !== 128'd0) begin
            bad++;
            $display("FAIL %s: actual outputs=%0h expected=0", name, v);
        end
    endtask

    // Spec-level outcome of one transaction given the responses the other caches give.
    function automatic exp_t predict(input int core, input logic [1:0] cmd,
                                     input logic [3:0] sh, input logic [3:0] fl, input int ack);
        exp_t e;
        logic [3:0] own;
        logic [3:0] s;
        logic [3:0] f;
        int nf;
        bit useMem;
        own = 4'b0001 << core;
        s = sh & ~own;
        f = fl & ~own;
        nf = $countones(f);
        useMem = (nf > 0) || (cmd != 2'b11);
        e.lat = useMem ? 2 + ack : 2;
        e.rd = (nf == 0 && useMem) ? ack : 0;
        e.wr = (nf > 0) ? ack : 0;
        e.sh = (cmd == 2'b01) && (s != 4'b0000);
        e.errNew = (nf > 1) || (cmd == 2'b11 && nf > 0);
        return e;
    endfunction

    function automatic int pickNext(input logic [3:0] pend, input int last);
        for (int k = 1; k <= NC; k++) begin
            int idx;
            idx = (last + k) % NC;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic driveReq(input int core, input logic [1:0] cmd, input logic [31:0] addr);
        busIf.req_valid[core]        = 1'b1;
        busIf.req_cmd[2*core +: 2]   = cmd;
        busIf.req_addr[AW*core +: AW] = addr;
    endtask

    task automatic clearInputs();
        busIf.req_valid    = '0;
        busIf.req_cmd      = '0;
        busIf.req_addr     = '0;
        busIf.snoop_shared = '0;
        busIf.snoop_flush  = '0;
        busIf.mem_ack      = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge of an IDLE cycle with requests already driven; returns at
    // the negedge of the following IDLE cycle. Acks memory after 'ack' request cycles.
    task automatic serveOne(input int ack, output obs_t o);
        o = '{src: -1, lat: -1, rd: 0, wr: 0, snoops: 0, gntBad: 0,
              sh: 1'b0, err: 1'b0, cmd: 2'b00, addr: 32'd0, doneVec: 4'd0};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busIf.snoop_valid) begin
                o.snoops++;
                o.src  = int'(busIf.snoop_src);
                o.cmd  = busIf.snoop_cmd;
                o.addr = busIf.snoop_addr;
            end
            if ($countones(busIf.bus_gnt) > 1) o.gntBad++;
            if (busIf.mem_rd_req) o.rd++;
            if (busIf.mem_wr_req) o.wr++;
            busIf.mem_ack = (busIf.mem_rd_req || busIf.mem_wr_req) && (o.rd + o.wr == ack);
            if (busIf.done != '0) begin
                o.lat     = c;
                o.doneVec = busIf.done;
                o.sh      = busIf.shared_out;
                o.err     = busIf.err;
                busIf.req_valid = busIf.req_valid & ~busIf.done;
                break;
            end
        end
        busIf.mem_ack = 1'b0;
        if (o.lat < 0) busIf.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic checkTxn(input string tag, input obs_t o, input int core,
                            input logic [1:0] cmd, input logic [31:0] addr,
                            input exp_t e, input logic errExp);
        check({tag, ".src"},    o.src, core);
        check({tag, ".lat"},    o.lat, e.lat);
        check({tag, ".rd"},     o.rd, e.rd);
        check({tag, ".wr"},     o.wr, e.wr);
        check({tag, ".shared"}, int'(o.sh), int'(e.sh));
        check({tag, ".err"},    int'(o.err), int'(errExp));
        check({tag, ".done"},   int'(o.doneVec), int'(4'b0001 << core));
        check({tag, ".snoops"}, o.snoops, 1);
        check({tag, ".onehot"}, o.gntBad, 0);
        check({tag, ".cmd"},    int'(o.cmd), int'(cmd));
        check({tag, ".addr"},   int'(o.addr), int'(addr));
    endtask

    vec_t tbl[7];

    initial begin
        obs_t o;
        exp_t e;
        logic errExp;
        int last;
        bit seen;
        logic [1:0]  cmdArr[NC];
        logic [31:0] addrArr[NC];

        tbl[0] = '{2, 2'b01, 32'h0000_1000, 4'b0000, 4'b0000, 3, 5, 3, 0, 1'b0};
        tbl[1] = '{0, 2'b01, 32'h0000_2000, 4'b0110, 4'b0000, 1, 3, 1, 0, 1'b1};
        tbl[2] = '{0, 2'b01, 32'h0000_2040, 4'b0001, 4'b0000, 2, 4, 2, 0, 1'b0};
        tbl[3] = '{1, 2'b01, 32'h0000_3000, 4'b0000, 4'b1000, 2, 4, 0, 2, 1'b0};
        tbl[4] = '{3, 2'b11, 32'h0000_4000, 4'b0010, 4'b0000, 0, 2, 0, 0, 1'b0};
        tbl[5] = '{1, 2'b10, 32'h0000_5000, 4'b1111, 4'b0000, 1, 3, 1, 0, 1'b0};
        tbl[6] = '{2, 2'b01, 32'h0000_6000, 4'b0000, 4'b0100, 1, 3, 1, 0, 1'b0};

        // Reset state while reset is held.
        rst = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        checkOutsZero("reset.outputs");
        rst = 1'b0;

        // Directed single transactions.
        for (int i = 0; i < 7; i++) begin
            busIf.snoop_shared = tbl[i].sh;
            busIf.snoop_flush  = tbl[i].fl;
            driveReq(tbl[i].core, tbl[i].cmd, tbl[i].addr);
            serveOne(tbl[i].ack, o);
            e = '{lat: tbl[i].lat, rd: tbl[i].rd, wr: tbl[i].wr, sh: tbl[i].shOut, errNew: 1'b0};
            checkTxn($sformatf("vec%0d", i), o, tbl[i].core, tbl[i].cmd, tbl[i].addr, e, 1'b0);
            busIf.snoop_shared = '0;
            busIf.snoop_flush  = '0;
        end

        // Round-robin with all cores requesting continuously.
        doReset();
        for (int i = 0; i < NC; i++) driveReq(i, 2'b01, 32'(i * 256));
        for (int n = 0; n < 5; n++) begin
            serveOne(1, o);
            check($sformatf("rr%0d.src", n), o.src, n % NC);
            check($sformatf("rr%0d.lat", n), o.lat, 3);
            check($sformatf("rr%0d.onehot", n), o.gntBad, 0);
            busIf.req_valid[n % NC] = 1'b1;
        end
        busIf.req_valid = '0;
        @(negedge clk);

        // Reset in the middle of a memory read.
        driveReq(1, 2'b01, 32'h0000_7000);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = busIf.mem_rd_req;
        end
        check("rstmid.reached_mem", int'(seen), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutsZero("rstmid.outputs");
        rst = 1'b0;
        busIf.req_valid = '0;

        // Double flush: sticky error.
        busIf.snoop_flush = 4'b1010;
        driveReq(0, 2'b01, 32'h0000_8000);
        serveOne(2, o);
        e = predict(0, 2'b01, 4'b0000, 4'b1010, 2);
        check("err.predicted", int'(e.errNew), 1);
        checkTxn("err.flush2", o, 0, 2'b01, 32'h0000_8000, e, 1'b1);
        busIf.snoop_flush = '0;
        driveReq(2, 2'b10, 32'h0000_9000);
        serveOne(1, o);
        e = predict(2, 2'b10, 4'b0000, 4'b0000, 1);
        checkTxn("err.sticky", o, 2, 2'b10, 32'h0000_9000, e, 1'b1);
        doReset();
        check("err.cleared", int'(busIf.err), 0);

        // Randomized rounds with simultaneous requesters against the model.
        errExp = 1'b0;
        last = NC - 1;
        for (int r = 0; r < 30; r++) begin
            logic [3:0] pend;
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < NC; i++) begin
                if (pend[i]) begin
                    cmdArr[i]  = 2'($urandom_range(1, 3));
                    addrArr[i] = $urandom & 32'hFFFF_FFC0;
                    driveReq(i, cmdArr[i], addrArr[i]);
                end
            end
            for (int k = 0; k < NC && pend != 4'b0000; k++) begin
                int w;
                int ack;
                logic [3:0] shV;
                logic [3:0] flV;
                w   = pickNext(pend, last);
                shV = 4'($urandom);
                flV = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                ack = $urandom_range(1, 4);
                busIf.snoop_shared = shV;
                busIf.snoop_flush  = flV;
                serveOne(ack, o);
                e = predict(w, cmdArr[w], shV, flV, ack);
                errExp = errExp | e.errNew;
                checkTxn($sformatf("rnd%0d_%0d", r, k), o, w, cmdArr[w], addrArr[w], e, errExp);
                busIf.snoop_shared = '0;
                busIf.snoop_flush  = '0;
                pend[w] = 1'b0;
                busIf.req_valid[w] = 1'b0;
                last = w;
            end
            busIf.req_valid = '0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
